// File: rtl/alu_pkg.sv
// Shared types and helpers for the alu_seq accumulator ALU.
// Intermediate results use one wide signed type so every op is computed exactly.
package alu_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int WIDE_W    = 2 * MAX_WIDTH + 2;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [2:0] {
        PASS = 3'b000,
        ADD  = 3'b001,
        SUB  = 3'b010,
        AND  = 3'b011,
        OR   = 3'b100,
        XOR  = 3'b101,
        MUL  = 3'b110,
        MAC  = 3'b111
    } alu_func_e;

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } alu_state_e;

    // Clamp value into the signed range of a width-bit word.
    function automatic wide_t sat_clip(input wide_t value, input int width);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (width - 1));
        if (value > hi)
            sat_clip = hi;
        else if (value < lo)
            sat_clip = lo;
        else
            sat_clip = value;
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Iterative radix-2 Booth signed multiplier, one iteration per cycle, WIDTH cycles.
// Done is high during the final iteration cycle with Product valid alongside it.
module seq_mult
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic signed [WIDTH-1:0]   A,
    input  logic signed [WIDTH-1:0]   B,
    output logic                      Busy,
    output logic                      Done,
    output logic signed [2*WIDTH-1:0] Product
);

    localparam int CW = $clog2(WIDTH + 1);

    // One guard bit on the partial product keeps subtracting a most-negative A exact.
    logic [WIDTH:0]   mcand_q;
    logic [WIDTH:0]   hi_q;
    logic [WIDTH:0]   hi_sum;
    logic [WIDTH:0]   hi_nxt;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] lo_nxt;
    logic             q1_q;
    logic [CW-1:0]    count_q;

    always_comb begin
        hi_sum = hi_q;
        case ({lo_q[0], q1_q})
            2'b01:   hi_sum = hi_q + mcand_q;
            2'b10:   hi_sum = hi_q - mcand_q;
            default: hi_sum = hi_q;
        endcase
        hi_nxt = {hi_sum[WIDTH], hi_sum[WIDTH:1]};
        lo_nxt = {hi_sum[0], lo_q[WIDTH-1:1]};
    end

    assign Done    = Busy && (count_q == CW'(WIDTH - 1));
    assign Product = {hi_nxt[WIDTH-1:0], lo_nxt};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Busy    <= 1'b0;
            count_q <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            q1_q    <= 1'b0;
        end else if (!Busy) begin
            if (Start) begin
                Busy    <= 1'b1;
                count_q <= '0;
                mcand_q <= {A[WIDTH-1], A};
                hi_q    <= '0;
                lo_q    <= B;
                q1_q    <= 1'b0;
            end
        end else begin
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            q1_q    <= lo_q[0];
            count_q <= count_q + CW'(1);
            if (Done)
                Busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Accumulator ALU: single-cycle logic/add ops, multi-cycle MUL/MAC with fixed-point
// scaling, optional saturation, Start/Busy/Done handshake for controller stalls.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 3
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [2:0]              Func,
    input  logic                    SelSW,
    input  logic                    SelImm,
    input  logic                    Sat,
    input  logic signed [WIDTH-1:0] Imm,
    input  logic signed [WIDTH-1:0] RegData,
    input  logic signed [WIDTH-1:0] SW,
    output logic signed [WIDTH-1:0] ACC,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Ovf
);

    alu_state_e state_q, state_d;
    alu_func_e  func_in, func_q, op_func;
    logic       sat_q, op_sat;
    logic       acc_we, mult_start, mult_busy, mult_done;
    logic       ovf_n;

    logic signed [WIDTH-1:0]   d;
    logic signed [WIDTH-1:0]   mcand;
    logic signed [WIDTH-1:0]   acc_n;
    logic signed [2*WIDTH-1:0] product;
    logic signed [2*WIDTH-1:0] prod_shift;
    wide_t                     acc_w, r, clipped;

    assign func_in    = alu_func_e'(Func);
    assign d          = SelSW ? SW : (SelImm ? Imm : RegData);
    assign mcand      = (func_in == MAC) ? d : ACC;
    assign prod_shift = product >>> FRAC;
    assign Busy       = mult_busy;

    // While multiplying, the latched op drives the result path so input changes are inert.
    assign op_func = (state_q == MULT) ? func_q : func_in;
    assign op_sat  = (state_q == MULT) ? sat_q  : Sat;

    seq_mult #(.WIDTH(WIDTH)) u_mult (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (mult_start),
        .A       (mcand),
        .B       (Imm),
        .Busy    (mult_busy),
        .Done    (mult_done),
        .Product (product)
    );

    always_comb begin
        acc_w = wide_t'(ACC);
        r     = wide_t'(d);
        case (op_func)
            PASS:    r = wide_t'(d);
            ADD:     r = acc_w + wide_t'(d);
            SUB:     r = acc_w - wide_t'(d);
            AND:     r = wide_t'(ACC & d);
            OR:      r = wide_t'(ACC | d);
            XOR:     r = wide_t'(ACC ^ d);
            MUL:     r = wide_t'(prod_shift);
            MAC:     r = acc_w + wide_t'(prod_shift);
            default: r = wide_t'(d);
        endcase
        clipped = sat_clip(r, WIDTH);
        ovf_n   = (clipped != r);
        acc_n   = (op_sat && ovf_n) ? clipped[WIDTH-1:0] : r[WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        acc_we     = 1'b0;
        mult_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (func_in < MUL) begin
                        acc_we = 1'b1;
                    end else begin
                        mult_start = 1'b1;
                        state_d    = MULT;
                    end
                end
            end
            MULT: begin
                if (mult_done) begin
                    acc_we  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            ACC     <= '0;
            Ovf     <= 1'b0;
            Done    <= 1'b0;
            func_q  <= PASS;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            Done    <= acc_we;
            if (acc_we) begin
                ACC <= acc_n;
                Ovf <= ovf_n;
            end
            if (mult_start) begin
                func_q <= func_in;
                sat_q  <= Sat;
            end
        end
    end

endmodule
